alu_exec_unit: RTL

- Parametrised successor to the combinational ALU control decoder for the RV64 pipeline's EX stage.
- Decodes ALUOp/Funct (base ops plus a shift/compare superset and an M-extension subset) and executes the operation.
- Base ops complete in one cycle; MUL/DIVU/REMU use an iterative multi-cycle datapath.
- Results are buffered in a registered output stage with valid/ready handshakes on both sides, so the hazard unit can stall on in_ready.

---
 rtl/alu_exec_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// RV64 EX-stage ALU: decodes ALUOp/funct and executes base, shift/compare
// and M-subset ops with a registered valid/ready output stage.
module alu_exec_unit #(
  parameter int XLEN      = 64,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [3:0]      funct,
  input  logic            m_ext,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      operation
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_REMU  = 4'b1100;
  localparam logic [3:0] OP_UNSUP = 4'b1110;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state_q, state_d;

  logic [SHW-1:0]  cnt_q;
  logic [3:0]      mop_q;
  logic [XLEN-1:0] acc_q, x_q, y_q;

  logic [3:0]      dec_op;
  logic [XLEN-1:0] sc_res;
  logic [SHW-1:0]  sh;
  logic            is_div, is_mc, accept, last;
  logic            ld_sc, ld_mc;
  logic [XLEN-1:0] ld_res, mc_res;
  logic [3:0]      ld_op;

  logic [XLEN-1:0] mul_acc_nx;
  logic [XLEN:0]   div_sh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_nx, div_quo_nx;

  always_comb begin
    dec_op = OP_ADD;
    unique case (1'b1)
      (alu_op == 2'b00):
        dec_op = (funct[2:0] == 3'b001) ? OP_SLL : OP_ADD;
      (alu_op == 2'b01):
        dec_op = OP_SUB;
      (alu_op == 2'b10 && !m_ext): begin
        case (funct)
          4'b0000: dec_op = OP_ADD;
          4'b1000: dec_op = OP_SUB;
          4'b0111: dec_op = OP_AND;
          4'b0110: dec_op = OP_OR;
          4'b0001: dec_op = OP_SLL;
          4'b0100: dec_op = OP_XOR;
          4'b0101: dec_op = OP_SRL;
          4'b1101: dec_op = OP_SRA;
          4'b0010: dec_op = OP_SLT;
          default: dec_op = OP_ADD;
        endcase
      end
      (alu_op == 2'b10 && m_ext): begin
        dec_op = OP_UNSUP;
        if (MULDIV_EN) begin
          case (funct[2:0])
            3'b000:  dec_op = OP_MUL;
            3'b101:  dec_op = OP_DIVU;
            3'b111:  dec_op = OP_REMU;
            default: dec_op = OP_UNSUP;
          endcase
        end
      end
      (alu_op == 2'b11):
        dec_op = OP_PASSB;
    endcase
  end

  assign sh = op_b[SHW-1:0];

  // Divide-by-zero takes the single-cycle path with RISC-V results.
  always_comb begin
    sc_res = '0;
    case (dec_op)
      OP_ADD:   sc_res = op_a + op_b;
      OP_SUB:   sc_res = op_a - op_b;
      OP_AND:   sc_res = op_a & op_b;
      OP_OR:    sc_res = op_a | op_b;
      OP_XOR:   sc_res = op_a ^ op_b;
      OP_SLL:   sc_res = op_a << sh;
      OP_SRL:   sc_res = op_a >> sh;
      OP_SRA:   sc_res = $signed(op_a) >>> sh;
      OP_SLT:   sc_res = {{(XLEN-1){1'b0}},
                          $signed(op_a) < $signed(op_b)};
      OP_DIVU:  sc_res = '1;
      OP_REMU:  sc_res = op_a;
      OP_PASSB: sc_res = op_b;
      default:  sc_res = '0;
    endcase
  end

  assign is_div = (dec_op == OP_DIVU) || (dec_op == OP_REMU);
  assign is_mc  = MULDIV_EN &&
                  ((dec_op == OP_MUL) || (is_div && op_b != '0));

  assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == '0);

  assign mul_acc_nx = y_q[0] ? acc_q + x_q : acc_q;

  // Restoring step: acc holds the partial remainder, x the quotient.
  assign div_sh     = {acc_q, x_q[XLEN-1]};
  assign div_diff   = div_sh - {1'b0, y_q};
  assign div_ge     = !div_diff[XLEN];
  assign div_rem_nx = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign div_quo_nx = {x_q[XLEN-2:0], div_ge};

  assign ld_sc  = accept && !is_mc;
  assign ld_mc  = (state_q != S_IDLE) && last;
  assign mc_res = (state_q == S_MUL) ? mul_acc_nx :
                  (mop_q == OP_REMU) ? div_rem_nx : div_quo_nx;
  assign ld_res = ld_sc ? sc_res : mc_res;
  assign ld_op  = ld_sc ? dec_op : mop_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (accept && is_mc)
          state_d = (dec_op == OP_MUL) ? S_MUL : S_DIV;
      S_MUL, S_DIV:
        if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      mop_q <= OP_AND;
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (accept && is_mc) begin
      cnt_q <= SHW'(XLEN-1);
      mop_q <= dec_op;
      acc_q <= '0;
      x_q   <= op_a;
      y_q   <= op_b;
    end else if (state_q == S_MUL) begin
      cnt_q <= cnt_q - SHW'(1);
      acc_q <= mul_acc_nx;
      x_q   <= x_q << 1;
      y_q   <= y_q >> 1;
    end else if (state_q == S_DIV) begin
      cnt_q <= cnt_q - SHW'(1);
      acc_q <= div_rem_nx;
      x_q   <= div_quo_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      operation <= 4'b0000;
    end else if (ld_sc || ld_mc) begin
      out_valid <= 1'b1;
      result    <= ld_res;
      zero      <= (ld_res == '0);
      operation <= ld_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
